// File: rtl/dma_ctrl_fsm.sv
// Word-by-word DMA transfer sequencer: read one word from the source, write it to
// the destination, repeat for the latched count, then pulse end-of-transfer.
module dma_ctrl_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sw_en,
  input  logic [7:0]            i_hw_en,
  input  logic [7:0]            i_dma_start_trig,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dist_addr,
  input  logic                  i_src_addr_type,
  input  logic                  i_dist_addr_type,
  input  logic [CNT_WIDTH-1:0]  i_total_trans,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic                  i_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_data_valid,
  output logic                  o_wr_valid,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_wr_ready,
  output logic                  o_trig_end_fsm,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_done_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] src_r;
  logic [ADDR_WIDTH-1:0] src_nxt_s;
  logic [ADDR_WIDTH-1:0] dst_r;
  logic [ADDR_WIDTH-1:0] dst_nxt_s;
  logic                  src_fix_r;
  logic                  src_fix_nxt_s;
  logic                  dst_fix_r;
  logic                  dst_fix_nxt_s;
  logic [CNT_WIDTH-1:0]  remain_r;
  logic [CNT_WIDTH-1:0]  remain_nxt_s;
  logic [CNT_WIDTH-1:0]  done_cnt_r;
  logic [CNT_WIDTH-1:0]  done_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] buf_r;
  logic [DATA_WIDTH-1:0] buf_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic                  rd_valid_r;
  logic                  wr_valid_r;
  logic                  trig_end_r;
  logic                  busy_r;
  logic                  start_s;

  assign start_s = i_sw_en | (|(i_hw_en & i_dma_start_trig));

  // Next-state and datapath update decode.
  always_comb begin
    state_nxt_s    = state_r;
    src_nxt_s      = src_r;
    dst_nxt_s      = dst_r;
    src_fix_nxt_s  = src_fix_r;
    dst_fix_nxt_s  = dst_fix_r;
    remain_nxt_s   = remain_r;
    done_cnt_nxt_s = done_cnt_r;
    buf_nxt_s      = buf_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          done_cnt_nxt_s = '0;
          if (i_total_trans != '0) begin
            src_nxt_s     = i_src_addr;
            dst_nxt_s     = i_dist_addr;
            src_fix_nxt_s = i_src_addr_type;
            dst_fix_nxt_s = i_dist_addr_type;
            remain_nxt_s  = i_total_trans;
            state_nxt_s   = ST_RD_REQ;
          end else begin
            state_nxt_s   = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (i_rd_ready) begin
          state_nxt_s = ST_RD_WAIT;
        end else begin
          state_nxt_s = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (i_rd_data_valid) begin
          buf_nxt_s   = i_rd_data;
          state_nxt_s = ST_WR_REQ;
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (i_wr_ready) begin
          done_cnt_nxt_s = done_cnt_r + CNT_WIDTH'(1);
          remain_nxt_s   = remain_r - CNT_WIDTH'(1);
          if (!src_fix_r) begin
            src_nxt_s = src_r + ADDR_STEP;
          end else begin
            src_nxt_s = src_r;
          end
          if (!dst_fix_r) begin
            dst_nxt_s = dst_r + ADDR_STEP;
          end else begin
            dst_nxt_s = dst_r;
          end
          if (remain_r == CNT_WIDTH'(1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RD_REQ;
          end
        end else begin
          state_nxt_s = ST_WR_REQ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and internal transfer context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      src_r      <= '0;
      dst_r      <= '0;
      src_fix_r  <= 1'b0;
      dst_fix_r  <= 1'b0;
      remain_r   <= '0;
      done_cnt_r <= '0;
      buf_r      <= '0;
    end else begin
      state_r    <= state_nxt_s;
      src_r      <= src_nxt_s;
      dst_r      <= dst_nxt_s;
      src_fix_r  <= src_fix_nxt_s;
      dst_fix_r  <= dst_fix_nxt_s;
      remain_r   <= remain_nxt_s;
      done_cnt_r <= done_cnt_nxt_s;
      buf_r      <= buf_nxt_s;
    end
  end

  // Outputs are decoded from the next state so they are registered yet still Moore-timed;
  // addresses load only when entering the request state and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      wr_valid_r <= 1'b0;
      trig_end_r <= 1'b0;
      busy_r     <= 1'b0;
      rd_addr_r  <= '0;
      wr_addr_r  <= '0;
    end else begin
      rd_valid_r <= (state_nxt_s == ST_RD_REQ);
      wr_valid_r <= (state_nxt_s == ST_WR_REQ);
      trig_end_r <= (state_nxt_s == ST_DONE);
      busy_r     <= (state_nxt_s != ST_IDLE);
      if (state_nxt_s == ST_RD_REQ) begin
        rd_addr_r <= src_nxt_s;
      end else begin
        rd_addr_r <= rd_addr_r;
      end
      if (state_nxt_s == ST_WR_REQ) begin
        wr_addr_r <= dst_nxt_s;
      end else begin
        wr_addr_r <= wr_addr_r;
      end
    end
  end

  assign o_rd_valid     = rd_valid_r;
  assign o_rd_addr      = rd_addr_r;
  assign o_wr_valid     = wr_valid_r;
  assign o_wr_addr      = wr_addr_r;
  assign o_wr_data      = buf_r;
  assign o_trig_end_fsm = trig_end_r;
  assign o_busy         = busy_r;
  assign o_done_cnt     = done_cnt_r;

endmodule

// File: tb/tb_dma_ctrl_fsm.sv
// Directed self-checking bench for dma_ctrl_fsm; each scenario task checks inline.
module tb_dma_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        i_sw_en;
  logic [7:0]  i_hw_en;
  logic [7:0]  i_dma_start_trig;
  logic [31:0] i_src_addr;
  logic [31:0] i_dist_addr;
  logic        i_src_addr_type;
  logic        i_dist_addr_type;
  logic [15:0] i_total_trans;
  logic        o_rd_valid;
  logic [31:0] o_rd_addr;
  logic        i_rd_ready;
  logic [31:0] i_rd_data;
  logic        i_rd_data_valid;
  logic        o_wr_valid;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        i_wr_ready;
  logic        o_trig_end_fsm;
  logic        o_busy;
  logic [15:0] o_done_cnt;

  int checks;
  int errors;

  dma_ctrl_fsm #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_sw_en          (i_sw_en),
    .i_hw_en          (i_hw_en),
    .i_dma_start_trig (i_dma_start_trig),
    .i_src_addr       (i_src_addr),
    .i_dist_addr      (i_dist_addr),
    .i_src_addr_type  (i_src_addr_type),
    .i_dist_addr_type (i_dist_addr_type),
    .i_total_trans    (i_total_trans),
    .o_rd_valid       (o_rd_valid),
    .o_rd_addr        (o_rd_addr),
    .i_rd_ready       (i_rd_ready),
    .i_rd_data        (i_rd_data),
    .i_rd_data_valid  (i_rd_data_valid),
    .o_wr_valid       (o_wr_valid),
    .o_wr_addr        (o_wr_addr),
    .o_wr_data        (o_wr_data),
    .i_wr_ready       (i_wr_ready),
    .o_trig_end_fsm   (o_trig_end_fsm),
    .o_busy           (o_busy),
    .o_done_cnt       (o_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    i_sw_en = 1'b0; i_hw_en = 8'h00; i_dma_start_trig = 8'h00;
    i_src_addr = 32'h0; i_dist_addr = 32'h0;
    i_src_addr_type = 1'b0; i_dist_addr_type = 1'b0; i_total_trans = 16'd0;
    i_rd_ready = 1'b0; i_rd_data = 32'h0; i_rd_data_valid = 1'b0; i_wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy});
    end
    checks++;
    if ({o_rd_addr, o_wr_addr, o_wr_data, o_done_cnt} !== 112'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {o_rd_addr, o_wr_addr, o_wr_data, o_done_cnt});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy got=%b exp=0", o_busy);
    end
  endtask

  // Zero-wait transfer: word w reads in cycle 3w+1, waits in 3w+2, writes in 3w+3.
  task automatic run_zero_wait(input logic [31:0] src, input logic [31:0] dst,
                               input logic stype, input logic dtype,
                               input logic [15:0] t, input logic use_hw, input string tag);
    logic exp_rv, exp_wv, exp_trig, exp_busy;
    logic [15:0] exp_cnt;
    logic [31:0] exp_addr, exp_data;
    int w;
    int ph;
    i_src_addr = src; i_dist_addr = dst;
    i_src_addr_type = stype; i_dist_addr_type = dtype; i_total_trans = t;
    i_rd_ready = 1'b1; i_rd_data_valid = 1'b1; i_wr_ready = 1'b1;
    if (use_hw) i_dma_start_trig = 8'h04;
    else i_sw_en = 1'b1;
    for (int c = 1; c <= 3 * int'(t) + 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        i_sw_en = 1'b0; i_dma_start_trig = 8'h00;
      end
      i_rd_data = 32'hCAFE_0000 | 32'(c);
      w = (c - 1) / 3;
      ph = (c - 1) % 3;
      if (c <= 3 * int'(t)) begin
        exp_rv = (ph == 0); exp_wv = (ph == 2); exp_trig = 1'b0; exp_busy = 1'b1; exp_cnt = 16'(w);
      end else if (c == 3 * int'(t) + 1) begin
        exp_rv = 1'b0; exp_wv = 1'b0; exp_trig = 1'b1; exp_busy = 1'b1; exp_cnt = t;
      end else begin
        exp_rv = 1'b0; exp_wv = 1'b0; exp_trig = 1'b0; exp_busy = 1'b0; exp_cnt = t;
      end
      checks++;
      if ({o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy} !== {exp_rv, exp_wv, exp_trig, exp_busy}) begin
        errors++;
        $display("FAIL %s ctrl cyc=%0d got rv/wv/trig/busy=%b exp=%b", tag, c,
                 {o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy}, {exp_rv, exp_wv, exp_trig, exp_busy});
      end
      checks++;
      if (o_done_cnt !== exp_cnt) begin
        errors++; $display("FAIL %s done_cnt cyc=%0d got=%0d exp=%0d", tag, c, o_done_cnt, exp_cnt);
      end
      if (exp_rv) begin
        exp_addr = src + (stype ? 32'h0 : 32'(4 * w));
        checks++;
        if (o_rd_addr !== exp_addr) begin
          errors++; $display("FAIL %s rd_addr cyc=%0d got=%h exp=%h", tag, c, o_rd_addr, exp_addr);
        end
      end
      if (exp_wv) begin
        exp_addr = dst + (dtype ? 32'h0 : 32'(4 * w));
        exp_data = 32'hCAFE_0000 | 32'(3 * w + 2);
        checks++;
        if (o_wr_addr !== exp_addr) begin
          errors++; $display("FAIL %s wr_addr cyc=%0d got=%h exp=%h", tag, c, o_wr_addr, exp_addr);
        end
        checks++;
        if (o_wr_data !== exp_data) begin
          errors++; $display("FAIL %s wr_data cyc=%0d got=%h exp=%h", tag, c, o_wr_data, exp_data);
        end
      end
    end
  endtask

  task automatic test_basic_inc();
    run_zero_wait(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 16'd4, 1'b0, "basic_inc");
  endtask

  task automatic test_fixed_src();
    run_zero_wait(32'h0000_3000, 32'h0000_2000, 1'b1, 1'b0, 16'd3, 1'b0, "fixed_src");
  endtask

  task automatic test_addr_wrap();
    run_zero_wait(32'h0000_1000, 32'hFFFF_FFFC, 1'b0, 1'b0, 16'd2, 1'b0, "addr_wrap");
  endtask

  task automatic test_hw_trigger();
    i_hw_en = 8'h04; i_dma_start_trig = 8'h02; i_total_trans = 16'd1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_busy, o_rd_valid} !== 2'b00) begin
        errors++; $display("FAIL hw_masked cyc=%0d got busy/rv=%b exp=00", c, {o_busy, o_rd_valid});
      end
    end
    run_zero_wait(32'h0000_8000, 32'h0000_9000, 1'b0, 1'b0, 16'd1, 1'b1, "hw_trigger");
    i_hw_en = 8'h00;
  endtask

  // Stalled slaves, a stray data beat during the read handshake, and config changes mid-transfer.
  task automatic test_backpressure();
    logic exp_rv, exp_wv, exp_trig, exp_busy;
    logic [15:0] exp_cnt;
    i_src_addr = 32'h0000_4000; i_dist_addr = 32'h0000_5000;
    i_src_addr_type = 1'b0; i_dist_addr_type = 1'b0; i_total_trans = 16'd2;
    i_rd_ready = 1'b0; i_rd_data_valid = 1'b0; i_wr_ready = 1'b0; i_rd_data = 32'h0;
    i_sw_en = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (c == 1) i_sw_en = 1'b0;
      if (c == 2) begin
        i_src_addr = 32'hDEAD_0000; i_total_trans = 16'd9;
      end
      i_rd_ready = (c == 6) || (c == 13);
      i_rd_data_valid = (c == 6) || (c == 8) || (c == 14);
      i_rd_data = (c == 6) ? 32'hBAD0_BAD0 : (c == 8) ? 32'h1111_AAAA : (c == 14) ? 32'h2222_BBBB : 32'h0;
      i_wr_ready = (c == 12) || (c == 15);
      exp_rv = (c <= 6) || (c == 13);
      exp_wv = (c >= 9 && c <= 12) || (c == 15);
      exp_trig = (c == 16);
      exp_busy = (c <= 16);
      exp_cnt = (c >= 16) ? 16'd2 : (c >= 13) ? 16'd1 : 16'd0;
      checks++;
      if ({o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy} !== {exp_rv, exp_wv, exp_trig, exp_busy}) begin
        errors++;
        $display("FAIL stall ctrl cyc=%0d got rv/wv/trig/busy=%b exp=%b", c,
                 {o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy}, {exp_rv, exp_wv, exp_trig, exp_busy});
      end
      checks++;
      if (o_done_cnt !== exp_cnt) begin
        errors++; $display("FAIL stall done_cnt cyc=%0d got=%0d exp=%0d", c, o_done_cnt, exp_cnt);
      end
      if (c <= 12) begin
        checks++;
        if (o_rd_addr !== 32'h0000_4000) begin
          errors++; $display("FAIL stall rd_addr cyc=%0d got=%h exp=00004000", c, o_rd_addr);
        end
      end
      if (c == 13) begin
        checks++;
        if (o_rd_addr !== 32'h0000_4004) begin
          errors++; $display("FAIL stall rd_addr2 cyc=%0d got=%h exp=00004004", c, o_rd_addr);
        end
      end
      if (c >= 9 && c <= 14) begin
        checks++;
        if ({o_wr_addr, o_wr_data} !== {32'h0000_5000, 32'h1111_AAAA}) begin
          errors++; $display("FAIL stall wr_word1 cyc=%0d got=%h exp=000050001111aaaa", c, {o_wr_addr, o_wr_data});
        end
      end
      if (c == 15) begin
        checks++;
        if ({o_wr_addr, o_wr_data} !== {32'h0000_5004, 32'h2222_BBBB}) begin
          errors++; $display("FAIL stall wr_word2 cyc=%0d got=%h exp=000050042222bbbb", c, {o_wr_addr, o_wr_data});
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    i_src_addr = 32'h0000_6000; i_dist_addr = 32'h0000_7000;
    i_src_addr_type = 1'b0; i_dist_addr_type = 1'b0; i_total_trans = 16'd3;
    i_rd_ready = 1'b1; i_rd_data_valid = 1'b1; i_wr_ready = 1'b0; i_rd_data = 32'h5A5A_5A5A;
    i_sw_en = 1'b1;
    @(posedge clk); #1;
    i_sw_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_wr_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid pre_wr_valid got=%b exp=1", o_wr_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL rstmid ctrl got=%b exp=0000", {o_rd_valid, o_wr_valid, o_trig_end_fsm, o_busy});
    end
    checks++;
    if ({o_rd_addr, o_wr_addr, o_wr_data, o_done_cnt} !== 112'h0) begin
      errors++; $display("FAIL rstmid data got=%h exp=0", {o_rd_addr, o_wr_addr, o_wr_data, o_done_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    i_wr_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_trig_end_fsm, o_busy, o_rd_valid, o_wr_valid} !== 4'b0000) begin
        errors++; $display("FAIL rstmid after cyc=%0d got trig/busy/rv/wv=%b exp=0000", c,
                           {o_trig_end_fsm, o_busy, o_rd_valid, o_wr_valid});
      end
    end
  endtask

  task automatic test_zero_count();
    i_total_trans = 16'd0; i_rd_ready = 1'b1; i_rd_data_valid = 1'b1; i_wr_ready = 1'b1;
    i_sw_en = 1'b1;
    @(posedge clk); #1;
    i_sw_en = 1'b0;
    checks++;
    if ({o_trig_end_fsm, o_busy, o_rd_valid, o_wr_valid} !== 4'b1100) begin
      errors++; $display("FAIL zero_cnt pulse got trig/busy/rv/wv=%b exp=1100",
                         {o_trig_end_fsm, o_busy, o_rd_valid, o_wr_valid});
    end
    checks++;
    if (o_done_cnt !== 16'd0) begin
      errors++; $display("FAIL zero_cnt done_cnt got=%0d exp=0", o_done_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({o_trig_end_fsm, o_busy, o_rd_valid, o_wr_valid} !== 4'b0000) begin
      errors++; $display("FAIL zero_cnt after got trig/busy/rv/wv=%b exp=0000",
                         {o_trig_end_fsm, o_busy, o_rd_valid, o_wr_valid});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_inc();
    test_fixed_src();
    test_hw_trigger();
    test_backpressure();
    test_addr_wrap();
    test_reset_mid_write();
    test_zero_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_ctrl_fsm.md
# dma_ctrl_fsm

Transfer sequencer for the DMA engine. It takes the configuration decoded by the DMA register file (source/destination address, address mode, transfer count, software and hardware enables) and runs one word-by-word read-then-write transfer over the engine's bus-master ports. On completion it pulses the end-of-transfer strobe back to the register file, which sets the interrupt status and clears the software enable.

## Interface
- DATA_WIDTH, 32: bus data width; must be a multiple of 8.
- ADDR_WIDTH, 32: bus address width.
- CNT_WIDTH, 16: width of the transfer count.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_sw_en  in  1  software start, level.
- i_hw_en  in  8  per-line hardware trigger enable mask.
- i_dma_start_trig  in  8  hardware request lines, level.
- i_src_addr  in  ADDR_WIDTH  start source address.
- i_dist_addr  in  ADDR_WIDTH  start destination address.
- i_src_addr_type  in  1  0 = increment, 1 = fixed.
- i_dist_addr_type  in  1  0 = increment, 1 = fixed.
- i_total_trans  in  CNT_WIDTH  number of words to move.
- o_rd_valid  out  1  read request valid.
- o_rd_addr  out  ADDR_WIDTH  read address.
- i_rd_ready  in  1  read request accepted.
- i_rd_data  in  DATA_WIDTH  read return data.
- i_rd_data_valid  in  1  read return data valid.
- o_wr_valid  out  1  write request valid.
- o_wr_addr  out  ADDR_WIDTH  write address.
- o_wr_data  out  DATA_WIDTH  write data.
- i_wr_ready  in  1  write accepted.
- o_trig_end_fsm  out  1  one-cycle end-of-transfer pulse.
- o_busy  out  1  high when the state is not IDLE.
- o_done_cnt  out  CNT_WIDTH  words completed in the current or last transfer.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE. Binary-encoded registered state; all control outputs are decoded from the state (Moore).
- start = i_sw_en | (|(i_hw_en & i_dma_start_trig)).
- IDLE:
  - If start and i_total_trans != 0: latch src, dst, both types and the count into internal registers; clear o_done_cnt; go to RD_REQ.
  - If start and i_total_trans == 0: go to DONE with no bus activity.
- RD_REQ: o_rd_valid = 1 and o_rd_addr = cur_src. On i_rd_ready, go to RD_WAIT.
- RD_WAIT: on i_rd_data_valid, capture i_rd_data into the data buffer and go to WR_REQ. i_rd_data_valid is ignored in all other states.
- WR_REQ: o_wr_valid = 1, o_wr_addr = cur_dst, o_wr_data = buffer. On i_wr_ready:
  - increment o_done_cnt and decrement the remaining count;
  - advance each address whose type is 0 by DATA_WIDTH/8;
  - go to DONE if remaining was 1, otherwise go to RD_REQ.
- DONE: o_trig_end_fsm = 1 for exactly one cycle, then go to IDLE unconditionally.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH; wrap past all-ones is silent. Fixed-type addresses never change.
- Configuration inputs are sampled only in IDLE. Changes during a transfer are ignored; start is ignored while busy.
- A start still asserted in IDLE after DONE begins a new transfer. The register file clears i_sw_en on the o_trig_end_fsm edge, so only a held hardware trigger retriggers.
- o_rd_addr, o_wr_addr and o_wr_data hold their values while the matching valid is low. The buffer holds the last word read.

## Timing
- Reset values: state IDLE; o_rd_valid, o_wr_valid, o_trig_end_fsm and o_busy 0; o_rd_addr, o_wr_addr, o_wr_data and o_done_cnt 0.
- Reset mid-transfer aborts immediately: no end pulse, and any outstanding bus request is dropped.
- Start in IDLE at cycle 0 puts o_rd_valid high at cycle 1.
- Valid holds until the ready cycle. It deasserts in the cycle after the handshake unless the next state asserts it again.
- With zero-wait slaves, each word takes 3 cycles. The end pulse for T words occurs at cycle 3T+1; for T = 0 it occurs at cycle 1.
- The earliest i_rd_data_valid is one cycle after i_rd_ready; data arriving in the same cycle as ready is not captured.

## Test plan
- i_sw_en=1, src=0x1000 (inc), dst=0x2000 (inc), T=4, zero-wait slaves -> reads 0x1000/04/08/0C, writes to 0x2000/04/08/0C with the matching data, o_trig_end_fsm pulse at cycle 13, o_done_cnt=4.
- src fixed 0x3000, dst inc, T=3 -> three reads all at 0x3000; writes to 0x2000/04/08.
- i_hw_en=0x04, i_dma_start_trig=0x02 -> no start; then trig=0x04 -> transfer starts the next cycle.
- i_rd_ready held low 5 cycles and i_wr_ready low 3 cycles -> valids and addresses stable throughout; no word lost; o_done_cnt increments only on write accept.
- T=0 with i_sw_en=1 -> no bus valids; end pulse at cycle 1; o_done_cnt=0.
- dst=0xFFFFFFFC (inc), T=2 -> second write to 0x00000000. Separately, assert rst mid-WR_REQ -> all outputs 0 and IDLE immediately, no end pulse.
